// File: rtl/wvl_ch_capture_if.sv
// Wavelength sample stream: time-multiplexed input and single-channel output.
// Pure wiring, no latency.
// No backpressure: the stream is valid-qualified only and the consumer must always accept.
interface wvl_ch_capture_if #(
  parameter int CH_W   = 8,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_ch;
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  // Stream source / sink side (drives the multiplexed stream, observes the selected channel)
  modport master (
    output in_data, in_ch, in_valid, in_sof,
    input  out_data, out_valid
  );

  // Channel-capture side
  modport slave (
    input  in_data, in_ch, in_valid, in_sof,
    output out_data, out_valid
  );
endinterface

// File: rtl/wvl_ch_capture.sv
// Selects one channel from a time-multiplexed wavelength stream and captures a burst of it.
// Passthrough latency 1 cycle; buffer read latency 1 cycle.
// No backpressure: every selected sample is forwarded and, while capturing, written to the buffer.
module wvl_ch_capture #(
  parameter int CH_W       = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [31:0]           sel_ch,
  wvl_ch_capture_if.slave       strm,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  miss
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

  state_t                state_q;
  logic                  arm_q;
  logic                  seen_low_q;
  logic                  seen_q;
  logic [CH_W-1:0]       ch_lat_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  done_q;
  logic                  miss_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  arm_now;
  logic                  arm_rise;
  logic                  arm_fall;
  logic                  sof;
  logic                  match;
  logic                  cap_match;
  logic                  cap_cycle;
  logic                  wr_en;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  unused_sel;

  assign unused_sel = ^sel_ch[30:CH_W];

  // Reset forces arm_q low, which would look like a rising edge if software left arm
  // high across reset; seen_low_q demands that arm is observed low at least once first.
  assign arm_now   = sel_ch[31];
  assign arm_rise  = arm_now & ~arm_q & seen_low_q;
  assign arm_fall  = ~arm_now & arm_q;
  assign sof       = strm.in_valid & strm.in_sof;
  assign match     = strm.in_valid & (strm.in_ch == sel_ch[CH_W-1:0]);
  assign cap_match = strm.in_valid & (strm.in_ch == ch_lat_q);
  // The sof cycle that leaves WAIT_SOF already counts as a capture cycle.
  assign cap_cycle = (state_q == CAPTURE) | ((state_q == WAIT_SOF) & sof);
  assign wr_en     = cap_cycle & cap_match & ~arm_fall & (count_q != FULL);
  assign count_d   = count_q + 1'b1;

  // Passthrough of the live-selected channel, independent of capture state
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= match;
      if (match) out_data_q <= strm.in_data;
    end
  end

  // Capture control FSM with arm edge detection and per-frame miss tracking
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      seen_low_q <= 1'b0;
      seen_q     <= 1'b0;
      ch_lat_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      arm_q <= arm_now;
      if (!arm_now) seen_low_q <= 1'b1;
      // Frame flag restarts at each sof with that cycle's own match
      if (sof)            seen_q <= cap_match;
      else if (cap_match) seen_q <= 1'b1;

      case (state_q)
        IDLE, DONE: begin
          if (arm_rise) begin
            ch_lat_q <= sel_ch[CH_W-1:0];
            count_q  <= '0;
            miss_q   <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= WAIT_SOF;
          end
        end
        WAIT_SOF, CAPTURE: begin
          if (arm_fall) begin
            state_q <= IDLE;
          end else begin
            if ((state_q == CAPTURE) && sof && !seen_q) miss_q <= 1'b1;
            if (cap_cycle) state_q <= CAPTURE;
            if (wr_en) begin
              count_q <= count_d;
              if (count_d == FULL) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture buffer write port; contents deliberately not reset
  always_ff @(posedge user_clk) begin
    if (wr_en) mem_q[count_q[DEPTH_LOG2-1:0]] <= strm.in_data;
  end

  // Registered readout; a same-address write in the same cycle returns the old word
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) rd_data_q <= '0;
    else             rd_data_q <= mem_q[rd_addr];
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign rd_data        = rd_data_q;
  assign busy           = (state_q == WAIT_SOF) | (state_q == CAPTURE);
  assign done           = done_q;
  assign count          = count_q;
  assign miss           = miss_q;

endmodule

// File: tb/tb_wvl_ch_capture.sv
// Directed bench for wvl_ch_capture on a 16-channel stream with a 1024-deep buffer.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// The DUT has no backpressure, so the stream runs every cycle.
module tb_wvl_ch_capture;
  localparam int CH_W = 4;
  localparam int DATA_W = 32;
  localparam int DL = 10;

  logic              user_clk = 1'b0;
  logic              user_rst_n;
  logic [31:0]       sel_ch;
  logic [DL-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [DL:0]       count;
  logic              miss;

  wvl_ch_capture_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  wvl_ch_capture #(.CH_W(CH_W), .DATA_W(DATA_W), .DEPTH_LOG2(DL)) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .sel_ch    (sel_ch),
    .strm      (bus),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .miss      (miss)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  int frame_n = 0;
  int ch_n = 0;
  int drop_frame = -1;
  int first_f = 0;
  int addrs[6] = '{0, 1, 499, 500, 501, 1023};

  function automatic logic [31:0] word(input int f, input int c);
    return 32'((f << 8) | c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cur();
    bus.in_valid = !((frame_n == drop_frame) && (ch_n == 5));
    bus.in_ch    = ch_n[CH_W-1:0];
    bus.in_sof   = (ch_n == 0);
    bus.in_data  = word(frame_n, ch_n);
  endtask

  // One clock edge consumes the presented sample; then the next one is presented
  task automatic tick();
    @(posedge user_clk);
    #1;
    ch_n++;
    if (ch_n == 16) begin
      ch_n = 0;
      frame_n++;
    end
    drive_cur();
  endtask

  task automatic run_until_ch(input int c);
    for (int i = 0; i < 16 && ch_n != c; i++) tick();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && !done; i++) tick();
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    // Reset state
    user_rst_n = 1'b0;
    sel_ch     = 32'h0000_0005;
    rd_addr    = '0;
    drive_cur();
    repeat (3) @(posedge user_clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_miss", 64'(miss), 64'd0);
    user_rst_n = 1'b1;

    // Passthrough of channel 5, one pulse per frame, one cycle after the sample
    repeat (2) begin
      run_until_ch(5);
      chk("pt_idle_valid", 64'(bus.out_valid), 64'd0);
      tick();
      chk("pt_valid", 64'(bus.out_valid), 64'd1);
      chk("pt_data", 64'(bus.out_data), 64'(word(frame_n, 5)));
      tick();
      chk("pt_valid_drop", 64'(bus.out_valid), 64'd0);
      chk("pt_data_hold", 64'(bus.out_data), 64'(word(frame_n, 5)));
    end
    chk("pt_busy", 64'(busy), 64'd0);
    chk("pt_done", 64'(done), 64'd0);

    // Arm mid-frame; capture starts at the next frame
    run_until_ch(10);
    sel_ch  = 32'h8000_0005;
    first_f = frame_n + 1;
    tick();
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_count", 64'(count), 64'd0);
    for (int i = 0; i < 40 && !(frame_n == first_f && ch_n == 6); i++) tick();
    chk("first_write_count", 64'(count), 64'd1);

    // Passthrough follows the new channel while the capture stays on channel 5
    for (int i = 0; i < 12000 && !(frame_n == first_f + 500 && ch_n == 0); i++) tick();
    sel_ch = 32'h8000_0009;
    run_until_ch(10);
    chk("sw_out_valid", 64'(bus.out_valid), 64'd1);
    chk("sw_out_data", 64'(bus.out_data), 64'(word(frame_n, 9)));

    wait_done();
    chk("cap1_done_frame", 64'(frame_n), 64'(first_f + 1023));
    chk("cap1_done_ch", 64'(ch_n), 64'd6);
    chk("cap1_count", 64'(count), 64'd1024);
    chk("cap1_miss", 64'(miss), 64'd0);
    chk("cap1_busy", 64'(busy), 64'd0);

    foreach (addrs[k]) begin
      rd_addr = addrs[k][DL-1:0];
      tick();
      chk("cap1_rd", 64'(rd_data), 64'(word(first_f + addrs[k], 5)));
    end
    chk("done_hold", 64'(done), 64'd1);
    chk("count_hold", 64'(count), 64'd1024);

    // Dropping arm alone leaves done set
    sel_ch = 32'h0000_0009;
    tick();
    tick();
    chk("fall_done_kept", 64'(done), 64'd1);
    chk("fall_busy", 64'(busy), 64'd0);

    // Capture with one frame missing channel 5
    run_until_ch(10);
    sel_ch     = 32'h8000_0005;
    first_f    = frame_n + 1;
    drop_frame = first_f + 10;
    tick();
    chk("rearm_done_clr", 64'(done), 64'd0);
    chk("rearm_busy", 64'(busy), 64'd1);
    chk("rearm_count", 64'(count), 64'd0);
    for (int i = 0; i < 400 && !(frame_n == drop_frame + 1 && ch_n == 0); i++) tick();
    chk("pre_miss", 64'(miss), 64'd0);
    chk("drop_count", 64'(count), 64'd10);
    tick();
    chk("miss_set", 64'(miss), 64'd1);
    wait_done();
    chk("cap2_done_frame", 64'(frame_n), 64'(first_f + 1024));
    chk("cap2_count", 64'(count), 64'd1024);
    chk("cap2_miss", 64'(miss), 64'd1);
    rd_addr = 10'd9;
    tick();
    chk("cap2_rd9", 64'(rd_data), 64'(word(first_f + 9, 5)));
    rd_addr = 10'd10;
    tick();
    chk("cap2_rd10", 64'(rd_data), 64'(word(first_f + 11, 5)));
    drop_frame = -1;

    // Abort at count 300
    sel_ch = 32'h0000_0005;
    tick();
    sel_ch = 32'h8000_0005;
    tick();
    chk("ab_busy", 64'(busy), 64'd1);
    chk("ab_done", 64'(done), 64'd0);
    for (int i = 0; i < 20000 && count != 11'd300; i++) tick();
    sel_ch = 32'h0000_0005;
    tick();
    chk("ab_idle_busy", 64'(busy), 64'd0);
    chk("ab_idle_done", 64'(done), 64'd0);
    chk("ab_count", 64'(count), 64'd300);
    repeat (20) tick();
    chk("ab_count_hold", 64'(count), 64'd300);
    sel_ch = 32'h8000_0005;
    tick();
    chk("ab_rearm_count", 64'(count), 64'd0);
    chk("ab_rearm_busy", 64'(busy), 64'd1);

    // Asynchronous reset mid-capture, then arm held high across reset
    for (int i = 0; i < 200 && count < 11'd3; i++) tick();
    run_until_ch(6);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #3;
    user_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_miss", 64'(miss), 64'd0);
    repeat (3) tick();
    user_rst_n = 1'b1;
    repeat (40) tick();
    chk("held_arm_busy", 64'(busy), 64'd0);
    chk("held_arm_count", 64'(count), 64'd0);
    sel_ch = 32'h0000_0005;
    tick();
    sel_ch = 32'h8000_0005;
    tick();
    chk("toggle_arm_busy", 64'(busy), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wvl_ch_capture.md
Name: wvl_ch_capture

Overview:
- Consumer of the software-written channel-select register (32-bit `sel_ch` word, already in the `user_clk` domain).
- Picks one resonator channel out of the time-multiplexed wavelength stream.
- Forwards that channel's samples as a single-channel stream.
- On software arm, captures a fixed-length burst of them into an internal buffer for readout by a snapshot/readout register block.

Parameters:
- CH_W, 8, width of channel index; channels 0..2^CH_W-1 per frame.
- DATA_W, 32, width of one wavelength sample.
- DEPTH_LOG2, 10, log2 of capture buffer depth (1024 samples).

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  asynchronous, active-low reset.
- sel_ch  in  32  control word from the register:
  - [CH_W-1:0] channel index.
  - [31] arm.
  - other bits ignored.
- in_data  in  DATA_W  stream sample.
- in_ch  in  CH_W  channel index of in_data.
- in_valid  in  1  sample qualifier.
- in_sof  in  1  first sample of a frame; meaningful only with in_valid.
- out_data  out  DATA_W  selected-channel sample.
- out_valid  out  1  out_data qualifier.
- rd_addr  in  DEPTH_LOG2  buffer read address.
- rd_data  out  DATA_W  buffer word, 1-cycle read latency.
- busy  out  1  capture in progress (WAIT_SOF or CAPTURE).
- done  out  1  buffer full; capture complete.
- count  out  DEPTH_LOG2+1  samples written in current/last capture.
- miss  out  1  sticky: a frame during capture contained no selected-channel sample.

Behaviour:
- Decided interface fact: one clock; reset is asynchronous and active-low (user_clk, user_rst_n).
- Reset values: out_data=0, out_valid=0, rd_data=0, busy=0, done=0, count=0, miss=0; state=IDLE; arm_d=0; ch_lat=0. Buffer contents are not reset.
- Reset asserted mid-capture returns to IDLE immediately, with all of the above values.
- arm_d is sel_ch[31] registered each cycle.
  - arm_rise = sel_ch[31] & ~arm_d.
  - arm_fall = ~sel_ch[31] & arm_d.
- Passthrough (independent of capture state):
  - match = in_valid & (in_ch == sel_ch[CH_W-1:0]), using the live register value.
  - Registered: out_valid <= match; out_data <= in_data when match, else hold.
  - Latency 1 cycle.
- FSM states: IDLE, WAIT_SOF, CAPTURE, DONE.
- IDLE:
  - On arm_rise: ch_lat <= sel_ch[CH_W-1:0]; count<=0; miss<=0; done<=0; go to WAIT_SOF.
- WAIT_SOF:
  - On in_valid & in_sof: go to CAPTURE, and that same cycle is treated as a CAPTURE cycle.
  - So a match on the sof sample itself (ch_lat==0) is written at address 0.
- CAPTURE:
  - Each cycle with cap_match = in_valid & (in_ch==ch_lat): write in_data at address count[DEPTH_LOG2-1:0]; count<=count+1.
  - When the write makes count == 2^DEPTH_LOG2: go to DONE, done<=1.
- Channel lock during capture:
  - Changes to sel_ch[CH_W-1:0] during WAIT_SOF/CAPTURE do not affect the capture, which uses ch_lat.
  - They do affect the passthrough.
- Miss detection:
  - Track seen_in_frame, cleared at each sof and set by cap_match.
  - In CAPTURE, an in_valid & in_sof with seen_in_frame==0 sets miss (sticky).
  - A match and an sof in the same cycle: the flag is evaluated on the previous frame, then re-initialized with this cycle's match.
- DONE:
  - done and count are held.
  - arm_rise starts a new capture exactly as from IDLE, clearing done.
  - arm_fall alone does not clear done.
- Abort: arm_fall in WAIT_SOF or CAPTURE goes to IDLE. count and miss keep their values; done stays 0.
- arm held high does not re-trigger; software must toggle arm low then high.
- busy = (state==WAIT_SOF) | (state==CAPTURE), decoded from registered state.
- Readout:
  - rd_data <= buf[rd_addr] every cycle.
  - Read-first on a same-cycle same-address write (old data returned).
  - Reads are allowed in any state.
- count width is DEPTH_LOG2+1 so that full = 2^DEPTH_LOG2 is representable. No write occurs at or beyond full.

Test Plan:
- Reset, then 256-channel stream (in_ch 0..255, in_sof at ch 0, in_data={frame,ch}), sel_ch=0x00000005 -> out_valid once per frame, 1 cycle after ch 5; out_data=data of ch 5; busy=0, done=0.
- sel_ch 0x05 -> 0x80000005 mid-frame -> busy=1 immediately. The first write happens in the next frame at address 0. After 1024 frames: done=1, count=1024, miss=0. rd_addr=k returns {k+first_frame, 5} one cycle later.
- During capture, write sel_ch=0x80000009 -> buffer still holds ch 5 samples; out_data switches to ch 9 from the next frame.
- Drop in_valid for ch 5 in one frame during capture -> miss=1 at the next sof. count ends at 1024, one frame later than without the drop.
- arm low at count=300 -> state IDLE, busy=0, done=0, count=300. Re-arm -> count resets to 0.
- Assert user_rst_n=0 asynchronously mid-capture -> all outputs 0 without waiting for a clock edge. After release with arm held high, no capture starts until arm is toggled.
